sfu_multi: RTL and testbench

//  Multi-channel special-function unit: col independent signed lanes, each

---
 rtl/sfu_pkg.sv | 23 ++
 rtl/sfu_lane.sv | 108 ++++++++++
 rtl/sfu_multi.sv | 95 +++++++++
 tb/tb_sfu_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared types and constant helpers for the multi-lane special-function unit.
package sfu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } sfu_state_e;

  function automatic int acc_width(input int psum_bw, input int guard_bw);
    return psum_bw + guard_bw;
  endfunction

  // Signed limits of a w-bit two's-complement number (w <= 31).
  function automatic int signed smax(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic int signed smin(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sfu_lane.sv
// One lane: guarded accumulator, overflow detect, optional ReLU, clamp, output register.
// Accumulator saturates when SFU_SAT_EN is defined, otherwise wraps with detection.
module sfu_lane
  import sfu_pkg::*;
#(
  parameter int psum_bw  = 16,
  parameter int guard_bw = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      accept,
  input  logic                      last,
  input  logic                      release_out,
  input  logic                      relu_en,
  input  logic signed [psum_bw-1:0] psum_in,
  output logic        [psum_bw-1:0] psum_out,
  output logic                      ovf
);

  localparam int acc_bw = acc_width(psum_bw, guard_bw);
  localparam logic signed [acc_bw-1:0] ACC_MAX = acc_bw'(smax(acc_bw));
  localparam logic signed [acc_bw-1:0] ACC_MIN = acc_bw'(smin(acc_bw));
  localparam logic signed [acc_bw-1:0] OUT_MAX = acc_bw'(smax(psum_bw));
  localparam logic signed [acc_bw-1:0] OUT_MIN = acc_bw'(smin(psum_bw));

  logic signed [acc_bw-1:0]  acc_q, acc_d;
  logic                      acc_ovf_q, acc_ovf_d;
  logic        [psum_bw-1:0] psum_out_q, psum_out_d;
  logic                      ovf_q, ovf_d;

  logic signed [acc_bw:0]    sum_s;
  logic                      add_ovf_s;
  logic signed [acc_bw-1:0]  sat_s, wrap_s, acc_next_s, x_s, f_s;
  logic        [psum_bw-1:0] clamp_s;
  logic                      clamp_ovf_s;

  // Datapath: one extra bit exposes the true sign of the sum for overflow and saturation.
  always_comb begin
    sum_s     = $signed({acc_q[acc_bw-1], acc_q})
              + $signed({{(guard_bw + 1){psum_in[psum_bw-1]}}, psum_in});
    add_ovf_s = sum_s[acc_bw] ^ sum_s[acc_bw-1];
    sat_s     = sum_s[acc_bw] ? ACC_MIN : ACC_MAX;
    wrap_s    = sum_s[acc_bw-1:0];
`ifdef SFU_SAT_EN
    acc_next_s = add_ovf_s ? sat_s : wrap_s;
`else
    acc_next_s = wrap_s;
`endif
    // A wrapped final add would flip the result's sign; report it in the overflow direction instead.
    x_s = add_ovf_s ? sat_s : wrap_s;
    f_s = (relu_en && x_s[acc_bw-1]) ? {acc_bw{1'b0}} : x_s;
    if (f_s > OUT_MAX) begin
      clamp_s     = OUT_MAX[psum_bw-1:0];
      clamp_ovf_s = 1'b1;
    end else if (f_s < OUT_MIN) begin
      clamp_s     = OUT_MIN[psum_bw-1:0];
      clamp_ovf_s = 1'b1;
    end else begin
      clamp_s     = f_s[psum_bw-1:0];
      clamp_ovf_s = 1'b0;
    end
  end

  // Next-state: clear beats everything, then last beat, plain beat, result release.
  always_comb begin
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    psum_out_d = psum_out_q;
    ovf_d      = ovf_q;
    if (clr) begin
      acc_d     = {acc_bw{1'b0}};
      acc_ovf_d = 1'b0;
      ovf_d     = 1'b0;
    end else if (accept && last) begin
      acc_d      = {acc_bw{1'b0}};
      acc_ovf_d  = 1'b0;
      psum_out_d = clamp_s;
      ovf_d      = acc_ovf_q | add_ovf_s | clamp_ovf_s;
    end else if (accept) begin
      acc_d     = acc_next_s;
      acc_ovf_d = acc_ovf_q | add_ovf_s;
    end else if (release_out) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= {acc_bw{1'b0}};
      acc_ovf_q  <= 1'b0;
      psum_out_q <= {psum_bw{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      psum_out_q <= psum_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign psum_out = psum_out_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/sfu_multi.sv
// Multi-channel special-function unit: stream FSM and valid/ready handshake over col lanes.
// Optional build macro: SFU_SAT_EN (saturating accumulators instead of wrap-detect).
module sfu_multi
  import sfu_pkg::*;
#(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int guard_bw = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   relu_en,
  input  logic                   valid_in,
  input  logic                   last_in,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] psum_out,
  output logic [col-1:0]         ovf
);

  sfu_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       beat_s, release_s;

  assign beat_s    = valid_in & in_ready_q & ~clr;
  assign release_s = (state_q == HOLD) & out_ready & ~clr;

  // Stream FSM; ready and valid are registered copies of the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (beat_s) begin
          state_d = last_in ? HOLD : ACC;
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  // Control registers; in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar k = 0; k < col; k++) begin : g_lane
    sfu_lane #(
      .psum_bw  (psum_bw),
      .guard_bw (guard_bw)
    ) u_lane (
      .clk         (clk),
      .rstn        (rstn),
      .clr         (clr),
      .accept      (beat_s),
      .last        (last_in),
      .release_out (release_s),
      .relu_en     (relu_en),
      .psum_in     (psum_in[k*psum_bw +: psum_bw]),
      .psum_out    (psum_out[k*psum_bw +: psum_bw]),
      .ovf         (ovf[k])
    );
  end

endmodule

// File: tb/tb_sfu_multi.sv
// Self-checking bench for sfu_multi: directed stream tests plus randomized traffic on two
// configurations (16b x 8 lanes, guard 4) and (4b x 2 lanes, guard 1) against a stream-level model.
module tb_sfu_multi;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic v_i [2];
  logic l_i [2];
  logic c_i [2];
  logic r_i [2];
  logic o_i [2];
  logic [127:0] din0;
  logic [7:0]   din1;

  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [127:0] pout0;
  logic [7:0]   pout1;
  logic [7:0]   ovf0;
  logic [1:0]   ovf1;

  sfu_multi #(.psum_bw(16), .col(8), .guard_bw(4)) dut0 (
    .clk(clk), .rstn(rstn), .clr(c_i[0]), .relu_en(r_i[0]), .valid_in(v_i[0]),
    .last_in(l_i[0]), .in_ready(in_ready0), .psum_in(din0), .out_valid(out_valid0),
    .out_ready(o_i[0]), .psum_out(pout0), .ovf(ovf0)
  );

  sfu_multi #(.psum_bw(4), .col(2), .guard_bw(1)) dut1 (
    .clk(clk), .rstn(rstn), .clr(c_i[1]), .relu_en(r_i[1]), .valid_in(v_i[1]),
    .last_in(l_i[1]), .in_ready(in_ready1), .psum_in(din1), .out_valid(out_valid1),
    .out_ready(o_i[1]), .psum_out(pout1), .ovf(ovf1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stream-level reference: exact integer sums, then the overflow/ReLU/clamp rules.
  longint m_acc  [2][8];
  bit     m_aovf [2][8];
  longint m_out  [2][8];
  bit     m_ovf  [2][8];
  bit     m_hold [2];
  bit     m_rdy  [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint lane_in(input int i, input int k);
    if (i == 0) return longint'($signed(din0[k*16 +: 16]));
    else        return longint'($signed(din1[k*4 +: 4]));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        m_acc[i][k] = 0; m_aovf[i][k] = 0; m_out[i][k] = 0; m_ovf[i][k] = 0;
      end
      m_hold[i] = 0;
      m_rdy[i]  = 0;
    end
  endfunction

  function automatic void model_edge(input int i);
    int     pb   = (i == 0) ? 16 : 4;
    int     ab   = (i == 0) ? 20 : 5;
    int     nc   = (i == 0) ? 8 : 2;
    longint amax = (longint'(1) << (ab - 1)) - 1;
    longint amin = -(longint'(1) << (ab - 1));
    longint pmax = (longint'(1) << (pb - 1)) - 1;
    longint pmin = -(longint'(1) << (pb - 1));
    if (c_i[i]) begin
      for (int k = 0; k < nc; k++) begin
        m_acc[i][k] = 0; m_aovf[i][k] = 0; m_ovf[i][k] = 0;
      end
      m_hold[i] = 0;
    end else if (m_hold[i]) begin
      if (o_i[i]) begin
        m_hold[i] = 0;
        for (int k = 0; k < nc; k++) m_ovf[i][k] = 0;
      end
    end else if (v_i[i] && m_rdy[i]) begin
      for (int k = 0; k < nc; k++) begin
        longint d  = lane_in(i, k);
        longint s  = m_acc[i][k] + d;
        bit     ao = (s > amax) || (s < amin);
`ifdef SFU_SAT_EN
        if (s > amax) s = amax;
        if (s < amin) s = amin;
`else
        if (s > amax) s = s - (longint'(1) << ab);
        if (s < amin) s = s + (longint'(1) << ab);
`endif
        if (l_i[i]) begin
          longint x = ao ? ((d >= 0) ? amax : amin) : s;
          bit     co = 0;
          if (r_i[i] && x < 0) x = 0;
          if (x > pmax) begin x = pmax; co = 1; end
          if (x < pmin) begin x = pmin; co = 1; end
          m_out[i][k]  = x;
          m_ovf[i][k]  = m_aovf[i][k] | ao | co;
          m_acc[i][k]  = 0;
          m_aovf[i][k] = 0;
        end else begin
          m_acc[i][k]  = s;
          m_aovf[i][k] = m_aovf[i][k] | ao;
        end
      end
      if (l_i[i]) m_hold[i] = 1;
    end
    m_rdy[i] = !m_hold[i];
  endfunction

  task automatic check_all();
    logic [127:0] e0;
    logic [7:0]   e1;
    logic [7:0]   f0;
    logic [1:0]   f1;
    for (int k = 0; k < 8; k++) begin
      e0[k*16 +: 16] = m_out[0][k][15:0];
      f0[k] = m_ovf[0][k];
    end
    for (int k = 0; k < 2; k++) begin
      e1[k*4 +: 4] = m_out[1][k][3:0];
      f1[k] = m_ovf[1][k];
    end
    check("in_ready0", in_ready0, m_rdy[0]);
    check("out_valid0", out_valid0, m_hold[0]);
    check("psum_out0", pout0, e0);
    check("ovf0", ovf0, f0);
    check("in_ready1", in_ready1, m_rdy[1]);
    check("out_valid1", out_valid1, m_hold[1]);
    check("psum_out1", pout1, e1);
    check("ovf1", ovf1, f1);
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
  endtask

  task automatic beat0(input logic [15:0] val, input bit last);
    din0 = {8{val}};
    v_i[0] = 1'b1;
    l_i[0] = last;
    step();
  endtask

  task automatic idle0();
    v_i[0] = 1'b0;
    l_i[0] = 1'b0;
    step();
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v_i[i] = 1'b0; l_i[i] = 1'b0; c_i[i] = 1'b0; r_i[i] = 1'b0; o_i[i] = 1'b1;
    end
    din0 = 128'd0;
    din1 = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;
    step();
    check("ready_after_reset", in_ready0, 1'b1);

    // T1: 1..5 with ReLU on -> 15.
    r_i[0] = 1'b1;
    for (int n = 1; n <= 5; n++) beat0(16'(n), n == 5);
    check("t1_sum", pout0[15:0], 16'd15);
    check("t1_valid", out_valid0, 1'b1);
    check("t1_ovf", ovf0[0], 1'b0);
    idle0();

    // T2: -3,+1 -> ReLU 0, then signed -2.
    beat0(-16'sd3, 1'b0);
    beat0(16'sd1, 1'b1);
    check("t2_relu", pout0[31:16], 16'd0);
    idle0();
    r_i[0] = 1'b0;
    beat0(-16'sd3, 1'b0);
    beat0(16'sd1, 1'b1);
    check("t2_signed", pout0[31:16], 16'hFFFE);
    idle0();

    // T3: backpressure for 5 cycles with a beat waiting.
    o_i[0] = 1'b0;
    beat0(16'd10, 1'b0);
    beat0(16'd20, 1'b1);
    din0 = {8{16'd100}};
    l_i[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check("t3_ready_low", in_ready0, 1'b0);
      check("t3_stable", pout0[15:0], 16'd30);
    end
    o_i[0] = 1'b1;
    step();
    step();
    v_i[0] = 1'b0;
    step();
    check("t3_no_loss", pout0[15:0], 16'd100);
    idle0();

    // T4: clamp overflow, then a clean stream clears ovf.
    for (int n = 0; n < 4; n++) beat0(16'd32767, n == 3);
    check("t4_clamp", pout0[15:0], 16'd32767);
    check("t4_ovf", ovf0, 8'hFF);
    idle0();
    beat0(16'd1, 1'b0);
    beat0(16'd1, 1'b1);
    check("t4_next", pout0[15:0], 16'd2);
    check("t4_ovf_clr", ovf0, 8'h00);
    idle0();

    // T5: clear mid-stream drops partial sums and the beat presented with it.
    beat0(16'd7, 1'b0);
    beat0(16'd7, 1'b0);
    c_i[0] = 1'b1;
    beat0(16'd99, 1'b1);
    c_i[0] = 1'b0;
    beat0(16'd4, 1'b1);
    check("t5_clr", pout0[15:0], 16'd4);
    idle0();
    beat0(16'd5, 1'b0);
    beat0(16'd6, 1'b0);
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    check("t5_rst_out", pout0, 128'd0);
    v_i[0] = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // T6: narrow config overflows its 5-bit accumulator.
    din1 = {4'd7, 4'd7};
    v_i[1] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      l_i[1] = (n == 2);
      step();
    end
    check("t6_out", pout1, 8'h77);
    check("t6_ovf", ovf1, 2'b11);
    v_i[1] = 1'b0;
    l_i[1] = 1'b0;
    step();

    // Random traffic on both configurations.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        v_i[i] = ($urandom_range(0, 9) < 7);
        l_i[i] = ($urandom_range(0, 3) == 0);
        c_i[i] = ($urandom_range(0, 39) == 0);
        r_i[i] = 1'($urandom_range(0, 1));
        o_i[i] = ($urandom_range(0, 9) < 6);
      end
      for (int k = 0; k < 8; k++) begin
        din0[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
      end
      din1 = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
